// File: rtl/lif_pkg.sv
// Shared types and reset defaults for the leaky integrate-and-fire neuron bank.
package lif_pkg;

  typedef enum logic {
    StIntegrate,
    StRefractory
  } lif_state_e;

  localparam int unsigned LifDefThresh    = 127;
  localparam int unsigned LifDefLeakShift = 1;
  localparam int unsigned LifDefRefrac    = 2;

  localparam int unsigned SpikeCntW = 16;

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: saturating integrator, leak shifter, refractory counter.
// Optional saturating spike counter when LIF_SPIKE_COUNT_EN is defined.
module lif_cell
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned REFRAC_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic [WIDTH-1:0]     current,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [3:0]           leak_shift,
  input  logic [REFRAC_W-1:0]  refrac,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                 cnt_clr,
  output logic [SpikeCntW-1:0] spike_count,
`endif
  output logic                 spike,
  output logic [WIDTH-1:0]     state
);

  lif_state_e          fsm_q, fsm_d;
  logic [WIDTH-1:0]    mem_q, mem_d;
  logic [REFRAC_W-1:0] cnt_q, cnt_d;
  logic                spike_q, spike_d;

  logic [WIDTH-1:0] leak;
  logic [WIDTH:0]   sum_raw;
  logic [WIDTH-1:0] sum;

  // Shifting by WIDTH or more would leave nothing; make that explicit.
  always_comb begin
    if (32'(leak_shift) >= WIDTH) begin
      leak = '0;
    end else begin
      leak = mem_q >> leak_shift;
    end
    sum_raw = {1'b0, current} + {1'b0, leak};
    sum     = sum_raw[WIDTH] ? '1 : sum_raw[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIntegrate;
      mem_q   <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (step) begin
      unique case (fsm_q)
        StIntegrate: begin
          if (sum >= threshold) begin
            mem_d   = '0;
            spike_d = 1'b1;
            if (refrac != '0) begin
              cnt_d = refrac;
              fsm_d = StRefractory;
            end
          end else begin
            mem_d = sum;
          end
        end
        StRefractory: begin
          mem_d = '0;
          cnt_d = cnt_q - 1'b1;
          // Leaving on a count of 1 skips exactly refrac steps.
          if (cnt_q <= REFRAC_W'(1)) begin
            cnt_d = '0;
            fsm_d = StIntegrate;
          end
        end
        default: fsm_d = StIntegrate;
      endcase
    end
  end

  always_comb begin
    spike = spike_q;
    state = mem_q;
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [SpikeCntW-1:0] scnt_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      scnt_q <= '0;
    end else if (spike_d && (scnt_q != '1)) begin
      scnt_q <= scnt_q + 1'b1;
    end
  end

  assign spike_count = scnt_q;
`endif

endmodule

// File: rtl/lif_array.sv
// Bank of NUM_CH independent LIF neurons sharing one run-time configuration.
// Define LIF_SPIKE_COUNT_EN to add per-channel saturating spike counters.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned REFRAC_W       = 4,
  parameter int unsigned DEF_THRESH     = LifDefThresh,
  parameter int unsigned DEF_LEAK_SHIFT = LifDefLeakShift,
  parameter int unsigned DEF_REFRAC     = LifDefRefrac
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step,
  input  logic [NUM_CH*WIDTH-1:0]     current,
  input  logic                        cfg_we,
  input  logic [WIDTH-1:0]            cfg_threshold,
  input  logic [3:0]                  cfg_leak_shift,
  input  logic [REFRAC_W-1:0]         cfg_refrac,
`ifdef LIF_SPIKE_COUNT_EN
  input  logic                        cnt_clr,
  output logic [NUM_CH*SpikeCntW-1:0] spike_count,
`endif
  output logic [NUM_CH-1:0]           spike,
  output logic [NUM_CH*WIDTH-1:0]     state
);

  logic [WIDTH-1:0]    thresh_q;
  logic [3:0]          leak_q;
  logic [REFRAC_W-1:0] refrac_q;

  // A step coinciding with cfg_we still sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_q <= WIDTH'(DEF_THRESH);
      leak_q   <= 4'(DEF_LEAK_SHIFT);
      refrac_q <= REFRAC_W'(DEF_REFRAC);
    end else if (cfg_we) begin
      thresh_q <= cfg_threshold;
      leak_q   <= cfg_leak_shift;
      refrac_q <= cfg_refrac;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lif_cell #(
      .WIDTH    (WIDTH),
      .REFRAC_W (REFRAC_W)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .step        (step),
      .current     (current[i*WIDTH +: WIDTH]),
      .threshold   (thresh_q),
      .leak_shift  (leak_q),
      .refrac      (refrac_q),
`ifdef LIF_SPIKE_COUNT_EN
      .cnt_clr     (cnt_clr),
      .spike_count (spike_count[i*SpikeCntW +: SpikeCntW]),
`endif
      .spike       (spike[i]),
      .state       (state[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_lif_array.sv
// Scoreboard bench for lif_array: driver queues hand-computed expectations, monitor compares.
module tb_lif_array;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned REFRAC_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    step;
  logic [NUM_CH*WIDTH-1:0] current;
  logic                    cfg_we;
  logic [WIDTH-1:0]        cfg_threshold;
  logic [3:0]              cfg_leak_shift;
  logic [REFRAC_W-1:0]     cfg_refrac;
  logic [NUM_CH-1:0]       spike;
  logic [NUM_CH*WIDTH-1:0] state;
`ifdef LIF_SPIKE_COUNT_EN
  logic                    cnt_clr = 1'b0;
  logic [NUM_CH*16-1:0]    spike_count;
`endif

  lif_array #(
    .WIDTH    (WIDTH),
    .NUM_CH   (NUM_CH),
    .REFRAC_W (REFRAC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .step           (step),
    .current        (current),
    .cfg_we         (cfg_we),
    .cfg_threshold  (cfg_threshold),
    .cfg_leak_shift (cfg_leak_shift),
    .cfg_refrac     (cfg_refrac),
`ifdef LIF_SPIKE_COUNT_EN
    .cnt_clr        (cnt_clr),
    .spike_count    (spike_count),
`endif
    .spike          (spike),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH*WIDTH-1:0] st;
    logic [NUM_CH-1:0]       sp;
    string                   name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [NUM_CH*WIDTH-1:0] pk(input logic [7:0] c0, input logic [7:0] c1,
                                                  input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Drive one cycle; the expectation describes outputs after this edge.
  task automatic cyc(input logic s, input logic [NUM_CH*WIDTH-1:0] cur,
                     input logic [NUM_CH*WIDTH-1:0] est, input logic [NUM_CH-1:0] esp,
                     input string name);
    exp_t e;
    step    = s;
    current = cur;
    @(posedge clk);
    e.st = est;
    e.sp = esp;
    e.name = name;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cfg(input logic [WIDTH-1:0] th, input logic [3:0] ls,
                     input logic [REFRAC_W-1:0] rf);
    cfg_we         = 1'b1;
    cfg_threshold  = th;
    cfg_leak_shift = ls;
    cfg_refrac     = rf;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (state === e.st) passes++;
      else $display("FAIL %s state: got %h expected %h", e.name, state, e.st);
      checks++;
      if (spike === e.sp) passes++;
      else $display("FAIL %s spike: got %b expected %b", e.name, spike, e.sp);
    end
  end

  initial begin
    rst = 1'b1;
    step = 1'b1;
    current = pk(200, 200, 200, 200);
    cfg(8'd5, 4'd0, 4'd0);

    // Reset overrides step and cfg_we.
    cyc(1, pk(200, 200, 200, 200), '0, '0, "reset");
    rst = 1'b0;
    cfg_we = 1'b0;

    // Integrate-to-fire with default config 127/1/2.
    cyc(1, pk(64, 40, 0, 0), pk(64, 40, 0, 0), 4'b0000, "int1");
    cyc(1, pk(64, 40, 0, 0), pk(96, 60, 0, 0), 4'b0000, "int2");
    cyc(1, pk(64, 40, 0, 0), pk(112, 70, 0, 0), 4'b0000, "int3");
    cyc(1, pk(64, 40, 0, 0), pk(120, 75, 0, 0), 4'b0000, "int4");
    cyc(1, pk(64, 40, 0, 0), pk(124, 77, 0, 0), 4'b0000, "int5");
    cyc(1, pk(64, 40, 0, 0), pk(126, 78, 0, 0), 4'b0000, "int6");
    cyc(1, pk(64, 40, 0, 0), pk(0, 79, 0, 0), 4'b0001, "int_fire");
    cyc(1, pk(64, 40, 0, 0), pk(0, 79, 0, 0), 4'b0000, "int_refr_a");
    cyc(1, pk(64, 40, 0, 0), pk(0, 79, 0, 0), 4'b0000, "int_refr_b");
    rst = 1'b1;
    cyc(1, pk(64, 40, 0, 0), '0, '0, "rst_mid");
    rst = 1'b0;

    // Saturation at threshold 255.
    cfg(8'd255, 4'd1, 4'd2);
    cyc(0, pk(200, 0, 0, 0), '0, '0, "cfg_hold");
    cfg_we = 1'b0;
    cyc(1, pk(200, 0, 0, 0), pk(200, 0, 0, 0), 4'b0000, "sat1");
    cyc(1, pk(200, 0, 0, 0), '0, 4'b0001, "sat_fire");

    // Refractory skips exactly two steps.
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0000, "refr1");
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0000, "refr2");
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0001, "refr_fire");

    // refrac 0 allows back-to-back spikes.
    cfg(8'd255, 4'd1, 4'd0);
    cyc(0, pk(255, 0, 0, 0), '0, '0, "cfg_r0");
    cfg_we = 1'b0;
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0000, "r0_drain1");
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0000, "r0_drain2");
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0001, "r0_fire1");
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0001, "r0_fire2");
    cyc(1, pk(255, 0, 0, 0), '0, 4'b0001, "r0_fire3");

    // Perfect integrator with strobe gaps.
    cfg(8'd50, 4'd0, 4'd2);
    cyc(0, pk(10, 0, 0, 0), '0, '0, "cfg_int");
    cfg_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1, pk(10, 0, 0, 0), pk(8'(10 * k), 0, 0, 0), 4'b0000, "gap_step");
      cyc(0, pk(10, 0, 0, 0), pk(8'(10 * k), 0, 0, 0), 4'b0000, "gap_hold_a");
      cyc(0, pk(10, 0, 0, 0), pk(8'(10 * k), 0, 0, 0), 4'b0000, "gap_hold_b");
    end
    cyc(1, pk(10, 0, 0, 0), '0, 4'b0001, "gap_fire");
    cyc(0, pk(10, 0, 0, 0), '0, 4'b0000, "gap_pulse");

    // Config/step collision: the step uses threshold 127, the next one 20.
    rst = 1'b1;
    cyc(1, pk(10, 0, 0, 0), '0, '0, "rst2");
    rst = 1'b0;
    cfg(8'd20, 4'd1, 4'd2);
    cyc(1, pk(30, 0, 0, 0), pk(30, 0, 0, 0), 4'b0000, "coll_old");
    cfg_we = 1'b0;
    cyc(1, pk(30, 0, 0, 0), '0, 4'b0001, "coll_new");

    // Reset while refractory returns to integrate with defaults.
    rst = 1'b1;
    cyc(1, pk(30, 0, 0, 0), '0, '0, "rst_refr");
    rst = 1'b0;
    cyc(1, pk(30, 0, 0, 0), pk(30, 0, 0, 0), 4'b0000, "post_rst");

    // Threshold 0 fires every channel.
    cfg(8'd0, 4'd1, 4'd0);
    cyc(0, pk(0, 0, 0, 0), pk(30, 0, 0, 0), 4'b0000, "cfg_t0");
    cfg_we = 1'b0;
    cyc(1, pk(0, 0, 0, 0), '0, 4'b1111, "t0_all");
    cyc(1, pk(0, 0, 0, 0), '0, 4'b1111, "t0_again");

    step = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
